serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first, one bit per clock.
// One full-subtractor cell with a registered borrow; start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             bout_q;
    logic             ovf_q;
    logic             amsb_q;
    logic             bmsb_q;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        ai    = a_q[0];
        bi    = b_q[0];
        d     = ai ^ bi ^ br_q;
        br_d  = (~ai & bi) | (~(ai ^ bi) & br_q);
        res_d = {d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        amsb_q  <= a[WIDTH-1];
                        bmsb_q  <= b[WIDTH-1];
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        // overflow only possible when operand signs differ
                        ovf_q   <= (amsb_q != bmsb_q) && (d != amsb_q);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
